// File: rtl/rgst_wr_arbiter.sv
// Write-port arbiter for the enable-gated register bank.
// Picks at most one requester per cycle and drives a one-hot register enable
// plus the shared write data. All outputs are registered.
// Optional build macro RGST_WR_ARB_FIXED_PRIO_EN: fixed priority (lowest
// eligible index wins, no rotating pointer). Without it: round-robin.
module rgst_wr_arbiter #(
   parameter int N    = 16,
   parameter int NREQ = 3,
   parameter int NREG = 8,
   parameter int AW   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 freeze,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*N-1:0]    req_data,
   output logic [NREQ-1:0]      gnt,
   output logic [NREG-1:0]      reg_en,
   output logic [N-1:0]         reg_d,
   output logic                 busy,
   output logic                 err_addr
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREG-1:0] reg_en_q, reg_en_d;
   logic [N-1:0]    reg_d_q, reg_d_d;
   logic            busy_q, busy_d;
   logic            err_addr_q, err_addr_d;

   logic [NREQ-1:0] elig;
   logic            found;
   logic [IW-1:0]   win;
   logic [AW-1:0]   addr_arr [NREQ];
   logic [N-1:0]    data_arr [NREQ];

   // Split the packed request buses into per-requester slices
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
      assign data_arr[gi] = req_data[gi*N +: N];
   end

   // The requester currently being granted is excluded so a held req is
   // never written twice; freeze suppresses every new grant.
   assign elig = freeze ? '0 : (req & ~gnt_q);

`ifdef RGST_WR_ARB_FIXED_PRIO_EN
   // Fixed priority: lowest eligible index wins
   always_comb begin
      found = |elig;
      win   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (elig[i]) win = IW'(i);
      end
   end
`else
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] upper;

   // Eligible requesters at or above the round-robin pointer
   always_comb begin
      upper = '0;
      for (int i = 0; i < NREQ; i++) begin
         upper[i] = elig[i] && (i >= int'(ptr_q));
      end
   end

   // First eligible from ptr upward; if none there, wrap to lowest eligible
   always_comb begin
      found = |elig;
      win   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (elig[i]) win = IW'(i);
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (upper[i]) win = IW'(i);
      end
   end

   // Pointer moves past the winner, only when a grant is issued
   always_comb begin
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`endif

   // Grant decode: one-hot grant, data capture, address decode / error flag
   always_comb begin
      gnt_d      = '0;
      reg_en_d   = '0;
      reg_d_d    = reg_d_q;
      err_addr_d = err_addr_q;
      if (found) begin
         gnt_d[win] = 1'b1;
         reg_d_d    = data_arr[win];
         if (int'(addr_arr[win]) < NREG) begin
            for (int j = 0; j < NREG; j++) begin
               reg_en_d[j] = (int'(addr_arr[win]) == j);
            end
         end else begin
            // Still granted so the requester is not stalled, but no register written
            err_addr_d = 1'b1;
         end
      end
      busy_d = |gnt_d;
   end

   // Output registers; reset discards any grant being computed this cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q      <= '0;
         reg_en_q   <= '0;
         reg_d_q    <= '0;
         busy_q     <= 1'b0;
         err_addr_q <= 1'b0;
      end else begin
         gnt_q      <= gnt_d;
         reg_en_q   <= reg_en_d;
         reg_d_q    <= reg_d_d;
         busy_q     <= busy_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign gnt      = gnt_q;
   assign reg_en   = reg_en_q;
   assign reg_d    = reg_d_q;
   assign busy     = busy_q;
   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_rgst_wr_arbiter.sv
// Testbench for rgst_wr_arbiter (NREG=6 so out-of-range addresses exist).
// Reference model: integer round-robin search (or fixed priority when
// RGST_WR_ARB_FIXED_PRIO_EN is defined) evaluated once per clock.
module tb_rgst_wr_arbiter;

   localparam int N    = 16;
   localparam int NREQ = 3;
   localparam int NREG = 6;
   localparam int AW   = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic                freeze;
   logic [NREQ-1:0]     req;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ*N-1:0]   req_data;
   logic [NREQ-1:0]     gnt;
   logic [NREG-1:0]     reg_en;
   logic [N-1:0]        reg_d;
   logic                busy;
   logic                err_addr;

   int errors = 0;
   int checks = 0;

   // reference model state
   int              m_ptr;
   int              m_gnt;
   logic [N-1:0]    m_reg_d;
   logic            m_err;
   logic [NREQ-1:0] exp_gnt;
   logic [NREG-1:0] exp_reg_en;
   logic            exp_busy;

   rgst_wr_arbiter #(.N(N), .NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .req(req),
      .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
      .reg_en(reg_en), .reg_d(reg_d), .busy(busy), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   // Advance the model by one clock edge using the inputs now applied
   task automatic model_step();
      int w;
      int i;
      int a;
      w = -1;
      if (rst) begin
         m_ptr = 0; m_gnt = -1; m_reg_d = '0; m_err = 1'b0;
         exp_gnt = '0; exp_reg_en = '0; exp_busy = 1'b0;
      end else begin
         if (!freeze) begin
            for (int k = 0; k < NREQ; k++) begin
`ifdef RGST_WR_ARB_FIXED_PRIO_EN
               i = k;
`else
               i = (m_ptr + k) % NREQ;
`endif
               if (w < 0 && req[i] && i != m_gnt) w = i;
            end
         end
         exp_gnt = '0;
         exp_reg_en = '0;
         if (w >= 0) begin
            exp_gnt[w] = 1'b1;
            m_ptr = (w + 1) % NREQ;
            m_reg_d = req_data[w*N +: N];
            a = int'(req_addr[w*AW +: AW]);
            if (a < NREG) exp_reg_en[a] = 1'b1;
            else m_err = 1'b1;
         end
         m_gnt = w;
         exp_busy = (w >= 0);
      end
   endtask

   // Apply one clock: inputs were set on the falling edge, outputs sampled on the next one
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [N-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*N +: N] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; freeze = 1'b0;
      tick(); tick();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({gnt, reg_en, reg_d, busy, err_addr} !== '0) begin
            errors++;
            $display("FAIL reset_idle cyc%0d: got gnt=%b en=%b d=%h busy=%b err=%b, want all zero",
                     c, gnt, reg_en, reg_d, busy, err_addr);
         end
      end
   endtask

   task automatic test_single_write();
      req = 3'b010; set_req(1, 3'd5, 16'hBEEF);
      tick();
      checks++;
      if (gnt !== 3'b010 || reg_en !== 6'b10_0000 || reg_d !== 16'hBEEF || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: got gnt=%b en=%b d=%h busy=%b, want 010 100000 beef 1",
                  gnt, reg_en, reg_d, busy);
      end
      tick();   // req1 still held during its grant cycle
      checks++;
      if (gnt !== 3'b000 || reg_en !== '0 || busy !== 1'b0 || reg_d !== 16'hBEEF) begin
         errors++;
         $display("FAIL single_no_regrant: got gnt=%b en=%b busy=%b d=%h, want 000 000000 0 beef",
                  gnt, reg_en, busy, reg_d);
      end
      req = '0;
      tick();
   endtask

   task automatic test_round_robin();
      int order [6];
`ifdef RGST_WR_ARB_FIXED_PRIO_EN
      order = '{0, 1, 0, 1, 0, 1};
`else
      order = '{0, 1, 2, 0, 1, 2};
`endif
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), N'(16'hA000 + i));
      req = 3'b111;
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++;
         if (gnt !== NREQ'(1 << order[c]) || reg_d !== m_reg_d || reg_en !== exp_reg_en) begin
            errors++;
            $display("FAIL rr_order step%0d: got gnt=%b d=%h en=%b, want gnt=%b d=%h en=%b",
                     c, gnt, reg_d, reg_en, NREQ'(1 << order[c]), m_reg_d, exp_reg_en);
         end
         // granted requester presents its next write straight away
         set_req(order[c], AW'(order[c] + 3), N'(16'hB000 + 16 * c + order[c]));
      end
      req = '0;
      tick();
   endtask

   task automatic test_out_of_range();
      req = 3'b001; set_req(0, 3'd7, 16'h1234);
      tick();
      checks++;
      if (gnt !== 3'b001 || reg_en !== '0 || err_addr !== 1'b1 || reg_d !== 16'h1234) begin
         errors++;
         $display("FAIL oor_grant: got gnt=%b en=%b err=%b d=%h, want 001 000000 1 1234",
                  gnt, reg_en, err_addr, reg_d);
      end
      req = '0;
      tick(); tick();
      req = 3'b010; set_req(1, 3'd2, 16'h5678);
      tick();
      checks++;
      if (gnt !== 3'b010 || reg_en !== 6'b00_0100 || err_addr !== 1'b1) begin
         errors++;
         $display("FAIL oor_sticky: got gnt=%b en=%b err=%b, want 010 000100 1", gnt, reg_en, err_addr);
      end
      req = '0;
      tick();
   endtask

   task automatic test_freeze_reset();
      rst = 1'b1; tick(); rst = 1'b0;
      freeze = 1'b1; req = 3'b101;
      set_req(0, 3'd1, 16'h0101); set_req(2, 3'd3, 16'h0303);
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (gnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL freeze_hold cyc%0d: got gnt=%b busy=%b, want 000 0", c, gnt, busy);
         end
      end
      freeze = 1'b0;
      tick();
      checks++;
      if (gnt !== 3'b001 || reg_en !== 6'b00_0010) begin
         errors++;
         $display("FAIL freeze_release: got gnt=%b en=%b, want 001 000010", gnt, reg_en);
      end
      req = 3'b100;
      tick();
      checks++;
      if (gnt !== 3'b100 || reg_d !== 16'h0303) begin
         errors++;
         $display("FAIL freeze_next: got gnt=%b d=%h, want 100 0303", gnt, reg_d);
      end
      // reset while a grant is on the outputs and another would be issued
      rst = 1'b1; req = 3'b011; set_req(1, 3'd7, 16'h7777);
      tick();
      checks++;
      if ({gnt, reg_en, reg_d, busy, err_addr} !== '0) begin
         errors++;
         $display("FAIL reset_discard: got gnt=%b en=%b d=%h busy=%b err=%b, want all zero",
                  gnt, reg_en, reg_d, busy, err_addr);
      end
      rst = 1'b0; req = 3'b110;
      tick();
      checks++;
      if (gnt !== 3'b010 || err_addr !== 1'b1) begin
         errors++;
         $display("FAIL reset_ptr: got gnt=%b err=%b, want 010 1", gnt, err_addr);
      end
      req = '0;
      tick();
   endtask

   task automatic test_alternate();
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), N'(16'hC000 + i));
      for (int c = 0; c < 4; c++) begin
         req = (c % 2 == 0) ? 3'b011 : 3'b110;
         tick();
         checks++;
         if (gnt !== NREQ'(1 << (c % 2)) || gnt !== exp_gnt) begin
            errors++;
            $display("FAIL alt_order step%0d: got gnt=%b, want %b", c, gnt, NREQ'(1 << (c % 2)));
         end
      end
      req = 3'b100;
      tick();
      checks++;
      if (gnt !== 3'b100 || reg_d !== 16'hC002) begin
         errors++;
         $display("FAIL alt_req2: got gnt=%b d=%h, want 100 c002", gnt, reg_d);
      end
      req = '0;
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            // a requester may change only when idle or in its grant cycle
            if (!req[i] || m_gnt == i) begin
               if ($urandom_range(0, 2) != 0) begin
                  req[i] = 1'b1;
                  set_req(i, AW'($urandom_range(0, 7)), N'($urandom));
               end else begin
                  req[i] = 1'b0;
               end
            end
         end
         freeze = ($urandom_range(0, 9) == 0);
         rst = ($urandom_range(0, 49) == 0);
         tick();
         checks++;
         if ({gnt, reg_en, reg_d, busy, err_addr} !== {exp_gnt, exp_reg_en, m_reg_d, exp_busy, m_err}) begin
            errors++;
            $display("FAIL random cyc%0d: got gnt=%b en=%b d=%h busy=%b err=%b, want gnt=%b en=%b d=%h busy=%b err=%b",
                     c, gnt, reg_en, reg_d, busy, err_addr, exp_gnt, exp_reg_en, m_reg_d, exp_busy, m_err);
         end
      end
      rst = 1'b0; freeze = 1'b0; req = '0;
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; req = '0; req_addr = '0; req_data = '0;
      m_ptr = 0; m_gnt = -1; m_reg_d = '0; m_err = 1'b0;
      exp_gnt = '0; exp_reg_en = '0; exp_busy = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_write();
      test_round_robin();
      test_out_of_range();
      test_freeze_reset();
      test_alternate();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
